// File: rtl/gpio_responder.sv
// gpio_responder: memory-mapped GPIO slave (bus: gpio_sel/wr_req/rd_req/w_addr/r_addr/w_data -> rd_data/rd_valid; pins: gpio_in -> gpio_out/gpio_oe; irq level interrupt)
module gpio_responder #(
  parameter int NUM_GPIO    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gpio_sel,
  input  logic                wr_req,
  input  logic                rd_req,
  input  logic [31:0]         w_addr,
  input  logic [31:0]         r_addr,
  input  logic [31:0]         w_data,
  output logic [31:0]         rd_data,
  output logic                rd_valid,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);
  logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] sync_q;
  logic [NUM_GPIO-1:0] out_reg, dir_reg, ien_reg, status_reg, prev_in;
  logic [NUM_GPIO-1:0] sync_in, rise, wd, out_n, dir_n, ien_n, w1c, status_n, rv;
  logic [9:0] wa, ra;
  logic we, re;
  logic unused_bits;
  assign unused_bits = ^{w_addr[31:12], w_addr[1:0], r_addr[31:12], r_addr[1:0], w_data};
  always_comb begin
    wa       = w_addr[11:2];
    ra       = r_addr[11:2];
    we       = gpio_sel & wr_req;
    re       = gpio_sel & rd_req & ~wr_req;
    wd       = w_data[NUM_GPIO-1:0];
    sync_in  = sync_q[SYNC_STAGES-1];
    rise     = sync_in & ~prev_in;
    out_n    = !we          ? out_reg :
               wa == 10'd0  ? wd :
               wa == 10'd5  ? out_reg | wd :
               wa == 10'd6  ? out_reg & ~wd :
               wa == 10'd7  ? out_reg ^ wd : out_reg;
    dir_n    = (we && wa == 10'd1) ? wd : dir_reg;
    ien_n    = (we && wa == 10'd3) ? wd : ien_reg;
    w1c      = (we && wa == 10'd4) ? wd : '0;
    status_n = (status_reg & ~w1c) | (rise & ~dir_reg);
    rv       = ra == 10'd0 ? out_reg :
               ra == 10'd1 ? dir_reg :
               ra == 10'd2 ? sync_in :
               ra == 10'd3 ? ien_reg :
               ra == 10'd4 ? status_reg : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      prev_in    <= '0;
      out_reg    <= '0;
      dir_reg    <= '0;
      ien_reg    <= '0;
      status_reg <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      prev_in    <= sync_in;
      out_reg    <= out_n;
      dir_reg    <= dir_n;
      ien_reg    <= ien_n;
      status_reg <= status_n;
      rd_valid   <= re;
      if (re) rd_data <= 32'(rv);
    end
  end
  assign gpio_out = out_reg;
  assign gpio_oe  = dir_reg;
  assign irq      = |(status_reg & ien_reg);
endmodule

// File: tb/tb_gpio_responder.sv
// tb_gpio_responder: directed bench with a per-cycle register-map model of gpio_responder
module tb_gpio_responder;
  localparam int N = 16;
  localparam int S = 2;
  localparam logic [31:0] MASK = (N == 32) ? 32'hFFFF_FFFF : ((32'd1 << N) - 32'd1);
  logic clk = 1'b0;
  logic rst, gpio_sel, wr_req, rd_req;
  logic [31:0] w_addr, r_addr, w_data, rd_data;
  logic rd_valid, irq;
  logic [N-1:0] gpio_in, gpio_out, gpio_oe;
  int errors = 0;
  int checks = 0;
  gpio_responder #(.NUM_GPIO(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .gpio_sel(gpio_sel), .wr_req(wr_req), .rd_req(rd_req),
    .w_addr(w_addr), .r_addr(r_addr), .w_data(w_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  logic [31:0] m_out = 0, m_dir = 0, m_ien = 0, m_st = 0, m_rdd = 0;
  logic m_rdv = 0;
  logic [31:0] hist [0:S];
  logic [31:0] p_now, p_rise, p_wd, p_rv;
  int p_wo, p_ro;
  bit p_we, p_re;
  initial for (int k = 0; k <= S; k++) hist[k] = 0;
  always @(posedge clk) begin
    p_now  = hist[S-1];
    p_rise = p_now & ~hist[S];
    p_we   = gpio_sel && wr_req;
    p_re   = gpio_sel && rd_req && !wr_req;
    p_wo   = int'(w_addr[11:2]);
    p_ro   = int'(r_addr[11:2]);
    p_wd   = w_data & MASK;
    case (p_ro)
      0: p_rv = m_out;
      1: p_rv = m_dir;
      2: p_rv = p_now;
      3: p_rv = m_ien;
      4: p_rv = m_st;
      default: p_rv = 0;
    endcase
    if (rst) begin
      m_out <= 0; m_dir <= 0; m_ien <= 0; m_st <= 0; m_rdd <= 0; m_rdv <= 0;
      for (int k = 0; k <= S; k++) hist[k] <= 0;
    end else begin
      if (p_we)
        case (p_wo)
          0: m_out <= p_wd;
          1: m_dir <= p_wd;
          3: m_ien <= p_wd;
          5: m_out <= m_out | p_wd;
          6: m_out <= m_out & ~p_wd;
          7: m_out <= m_out ^ p_wd;
          default: ;
        endcase
      m_st  <= (m_st & ~((p_we && p_wo == 4) ? p_wd : 32'd0)) | (p_rise & ~m_dir);
      m_rdv <= p_re;
      if (p_re) m_rdd <= p_rv;
      hist[0] <= 32'(gpio_in);
      for (int k = 1; k <= S; k++) hist[k] <= hist[k-1];
    end
  end
  always @(negedge clk) begin
    chk("model gpio_out", 32'(gpio_out), m_out);
    chk("model gpio_oe", 32'(gpio_oe), m_dir);
    chk("model irq", 32'(irq), 32'(|(m_st & m_ien)));
    chk("model rd_valid", 32'(rd_valid), 32'(m_rdv));
    if (m_rdv) chk("model rd_data", rd_data, m_rdd);
  end
  task automatic write(input logic [31:0] a, input logic [31:0] d);
    gpio_sel = 1; wr_req = 1; w_addr = a; w_data = d;
    @(negedge clk);
    gpio_sel = 0; wr_req = 0;
  endtask
  task automatic read(input logic [31:0] a, input logic [31:0] exp, input string name);
    gpio_sel = 1; rd_req = 1; r_addr = a;
    @(negedge clk);
    gpio_sel = 0; rd_req = 0;
    chk({name, " valid"}, 32'(rd_valid), 32'd1);
    chk({name, " data"}, rd_data, exp);
  endtask
  initial begin
    rst = 1; gpio_sel = 0; wr_req = 0; rd_req = 0;
    w_addr = 0; r_addr = 0; w_data = 0; gpio_in = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset gpio_out", 32'(gpio_out), 0);
    chk("reset gpio_oe", 32'(gpio_oe), 0);
    chk("reset irq", 32'(irq), 0);
    chk("reset rd_valid", 32'(rd_valid), 0);
    read(32'h00, 0, "reset OUT");
    read(32'h04, 0, "reset DIR");
    read(32'h10, 0, "reset STATUS");
    write(32'h00, 32'h00F0);
    write(32'h14, 32'h0003);
    write(32'h18, 32'h0010);
    write(32'h1C, 32'h0101);
    chk("out ops gpio_out", 32'(gpio_out), 32'h01E2);
    read(32'h00, 32'h01E2, "out ops OUT");
    gpio_in = 16'h0005; gpio_sel = 1; rd_req = 1; r_addr = 32'h08;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("in latency", rd_data, (k < 3) ? 32'h0 : 32'h5);
    end
    gpio_sel = 0; rd_req = 0; gpio_in = 0;
    repeat (4) @(negedge clk);
    write(32'h10, 32'hFFFF);
    read(32'h10, 0, "status cleared");
    write(32'h0C, 32'h0004);
    gpio_in = 16'h0004;
    repeat (2) @(negedge clk);
    chk("irq before", 32'(irq), 0);
    @(negedge clk);
    chk("irq at 3", 32'(irq), 1);
    read(32'h10, 32'h4, "status bit2");
    gpio_in = 16'h000C;
    repeat (4) @(negedge clk);
    chk("irq held", 32'(irq), 1);
    read(32'h10, 32'hC, "status bit2+3");
    write(32'h10, 32'h0004);
    chk("irq cleared", 32'(irq), 0);
    read(32'h10, 32'h8, "status after w1c");
    gpio_in = 16'h000E;
    repeat (2) @(negedge clk);
    write(32'h10, 32'h0002);
    read(32'h10, 32'hA, "set beats clear");
    write(32'h04, 32'h0010);
    chk("dir gpio_oe", 32'(gpio_oe), 32'h10);
    gpio_in = 16'h001E;
    repeat (4) @(negedge clk);
    read(32'h10, 32'hA, "dir pin no status");
    read(32'h08, 32'h1E, "dir pin in IN");
    gpio_sel = 1; wr_req = 1; rd_req = 1; w_addr = 0; w_data = 32'h55; r_addr = 0;
    @(negedge clk);
    chk("priority no rd_valid", 32'(rd_valid), 0);
    chk("priority write", 32'(gpio_out), 32'h55);
    gpio_sel = 0; w_data = 32'hAA;
    @(negedge clk);
    wr_req = 0; rd_req = 0;
    chk("unsel no rd_valid", 32'(rd_valid), 0);
    chk("unsel no write", 32'(gpio_out), 32'h55);
    read(32'h40, 0, "unmapped");
    read(32'h14, 0, "write-only");
    write(32'h08, 32'hFFFF);
    read(32'h08, 32'h1E, "IN ignores write");
    write(32'h00, 32'hFFFF_FFFF);
    read(32'h03, 32'h0000_FFFF, "upper bits zero");
    read(32'hF000_0004, 32'h10, "window alias");
    gpio_sel = 1; rd_req = 1; r_addr = 0; rst = 1;
    @(negedge clk);
    gpio_sel = 0; rd_req = 0; rst = 0;
    chk("rst mid rd_valid", 32'(rd_valid), 0);
    chk("rst mid gpio_out", 32'(gpio_out), 0);
    chk("rst mid gpio_oe", 32'(gpio_oe), 0);
    gpio_in = 0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
